mem_req_ctrl: RTL and testbench

- Synthesizable request controller that sits directly upstream of mem_system_hier, between the pipeline memory stage and the cache/memory system.
- Accepts one read or write per valid/ready handshake and drives Addr/DataIn/Rd/Wr to mem_system, holding them stable until Done.
- Returns the read data and hit status to the pipeline as a one-cycle response pulse.
- Checks hit and miss latency in hardware, aborts hung requests, and keeps hit/request statistics.

---
 rtl/mem_req_ctrl_if.sv | 35 +++
 rtl/mem_req_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// rtl/mem_req_ctrl_if.sv - pipeline request/response and mem_system bus bundle
interface mem_req_ctrl_if;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_hit;
  logic        resp_err;
  logic [15:0] mem_Addr;
  logic [15:0] mem_DataIn;
  logic        mem_Rd;
  logic        mem_Wr;
  logic [15:0] mem_DataOut;
  logic        mem_Done;
  logic        mem_Stall;
  logic        mem_CacheHit;

  // master: the pipeline plus mem_system environment around the controller
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    output mem_DataOut, mem_Done, mem_Stall, mem_CacheHit,
    input  req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    input  mem_Addr, mem_DataIn, mem_Rd, mem_Wr
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  mem_DataOut, mem_Done, mem_Stall, mem_CacheHit,
    output req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    output mem_Addr, mem_DataIn, mem_Rd, mem_Wr
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - request controller in front of mem_system_hier
module mem_req_ctrl #(
  parameter int HIT_MAX  = 2,
  parameter int MISS_MAX = 20,
  parameter int TIMEOUT  = 32,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_req_ctrl_if.slave      bus,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   stat_reqs,
  output logic [CNT_W-1:0]   stat_hits,
  output logic               perf_err,
  output logic               timeout_err
);

  localparam int LAT_W = $clog2(TIMEOUT + 1);
  localparam logic [LAT_W-1:0] HIT_L  = LAT_W'(HIT_MAX);
  localparam logic [LAT_W-1:0] MISS_L = LAT_W'(MISS_MAX);
  localparam logic [LAT_W-1:0] TMO_L  = LAT_W'(TIMEOUT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [15:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_hit_q, resp_hit_d;
  logic             resp_err_q, resp_err_d;
  logic [CNT_W-1:0] reqs_q, reqs_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             perf_q, perf_d;
  logic             tmo_q, tmo_d;
  logic             ready_c;
  logic             lat_bad_c;

  assign ready_c = (state_q == IDLE) && !bus.mem_Stall;

  // A miss faster than the hit window is as suspicious as one slower than MISS_MAX
  assign lat_bad_c = bus.mem_CacheHit ? (lat_q > HIT_L)
                                      : ((lat_q > MISS_L) || (lat_q <= HIT_L));

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_hit_d   = resp_hit_q;
    resp_err_d   = resp_err_q;
    reqs_d       = reqs_q;
    hits_d       = hits_q;
    perf_d       = perf_q;
    tmo_d        = tmo_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_Done) begin
          perf_d = 1'b1;
        end
        if (bus.req_valid && ready_c) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wr ? bus.req_wdata : 16'h0000;
          wr_d    = bus.req_wr;
          rd_d    = !bus.req_wr;
          lat_d   = LAT_W'(1);
          state_d = BUSY;
        end
      end
      default: begin
        if (bus.mem_Done) begin
          state_d      = IDLE;
          lat_d        = '0;
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_hit_d   = bus.mem_CacheHit;
          resp_rdata_d = rd_q ? bus.mem_DataOut : 16'h0000;
          resp_err_d   = 1'b0;
          reqs_d       = reqs_q + CNT_W'(1);
          if (bus.mem_CacheHit) begin
            hits_d = hits_q + CNT_W'(1);
          end
          if (lat_bad_c) begin
            perf_d = 1'b1;
          end
        end else if (lat_q == TMO_L) begin
          state_d      = IDLE;
          lat_d        = '0;
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_rdata_d = 16'h0000;
          resp_err_d   = 1'b1;
          reqs_d       = reqs_q + CNT_W'(1);
          tmo_d        = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
    endcase

    // Clearing wins over any same-cycle update; the request itself is untouched
    if (clr_stats) begin
      reqs_d = '0;
      hits_d = '0;
      perf_d = 1'b0;
      tmo_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      reqs_q       <= '0;
      hits_q       <= '0;
      perf_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_hit_q   <= resp_hit_d;
      resp_err_q   <= resp_err_d;
      reqs_q       <= reqs_d;
      hits_q       <= hits_d;
      perf_q       <= perf_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_Addr   = addr_q;
  assign bus.mem_DataIn = wdata_q;
  assign bus.mem_Rd     = rd_q;
  assign bus.mem_Wr     = wr_q;
  assign stat_reqs      = reqs_q;
  assign stat_hits      = hits_q;
  assign perf_err       = perf_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_stats;
  logic [15:0] stat_reqs;
  logic [15:0] stat_hits;
  logic        perf_err;
  logic        timeout_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_req_ctrl_if bus ();

  mem_req_ctrl #(.HIT_MAX(2), .MISS_MAX(20), .TIMEOUT(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .clr_stats   (clr_stats),
    .stat_reqs   (stat_reqs),
    .stat_hits   (stat_hits),
    .perf_err    (perf_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  // lat = 0 means mem_Done is never raised, so the request must time out
  task automatic run_req(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int lat, input logic hit,
                         input logic [15:0] dout);
    int held = 0;
    logic [15:0] exp_rdata;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if ((wr ? bus.mem_Wr : bus.mem_Rd) && !(wr ? bus.mem_Rd : bus.mem_Wr) &&
          bus.mem_Addr == addr && bus.mem_DataIn == (wr ? wdata : 16'h0000))
        held++;
      else
        break;
      if (c == lat) begin
        bus.mem_Done     = 1'b1;
        bus.mem_CacheHit = hit;
        bus.mem_DataOut  = dout;
      end
      tick();
      bus.mem_Done     = 1'b0;
      bus.mem_CacheHit = 1'b0;
    end
    exp_rdata = (wr || lat == 0) ? 16'h0000 : dout;
    check({tag, "_held"}, held, (lat == 0) ? 32 : lat);
    check({tag, "_rvalid"}, bus.resp_valid, 1'b1);
    check({tag, "_rhit"}, bus.resp_hit, (lat == 0) ? 1'b0 : hit);
    check({tag, "_rerr"}, bus.resp_err, (lat == 0) ? 1'b1 : 1'b0);
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    tick();
    check({tag, "_rvalid_drop"}, bus.resp_valid, 1'b0);
    check({tag, "_rdata_hold"}, bus.resp_rdata, exp_rdata);
  endtask

  initial begin
    int bad;
    clr_stats        = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_wr       = 1'b0;
    bus.req_addr     = 16'h0000;
    bus.req_wdata    = 16'h0000;
    bus.mem_DataOut  = 16'h0000;
    bus.mem_Done     = 1'b0;
    bus.mem_Stall    = 1'b0;
    bus.mem_CacheHit = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick();
    check("rst_rd", bus.mem_Rd, 1'b0);
    check("rst_wr", bus.mem_Wr, 1'b0);
    check("rst_rvalid", bus.resp_valid, 1'b0);
    check("rst_reqs", stat_reqs, 16'd0);
    check("rst_perf", perf_err, 1'b0);
    rst = 1'b1;
    tick();

    run_req("wr_hit1", 1'b1, 16'h0010, 16'h1234, 1, 1'b1, 16'h0000);
    check("wr_hit1_reqs", stat_reqs, 16'd1);
    check("wr_hit1_hits", stat_hits, 16'd1);
    check("wr_hit1_perf", perf_err, 1'b0);

    run_req("rd_miss9", 1'b0, 16'h0010, 16'hFFFF, 9, 1'b0, 16'h1234);
    check("rd_miss9_perf", perf_err, 1'b0);
    check("rd_miss9_reqs", stat_reqs, 16'd2);

    pulse_clr();
    check("clr_reqs", stat_reqs, 16'd0);
    run_req("hit2", 1'b0, 16'h0040, 16'h0000, 2, 1'b1, 16'hA5A5);
    run_req("miss20", 1'b0, 16'h0041, 16'h0000, 20, 1'b0, 16'h5A5A);
    check("edge_perf", perf_err, 1'b0);

    pulse_clr();
    run_req("miss21", 1'b0, 16'h0050, 16'h0000, 21, 1'b0, 16'h1111);
    check("miss21_perf", perf_err, 1'b1);
    run_req("hit3", 1'b1, 16'h0051, 16'h2222, 3, 1'b1, 16'h0000);
    check("hit3_perf", perf_err, 1'b1);
    check("hit3_hits", stat_hits, 16'd1);

    pulse_clr();
    run_req("miss2", 1'b0, 16'h0060, 16'h0000, 2, 1'b0, 16'h3333);
    check("miss2_perf", perf_err, 1'b1);

    pulse_clr();
    bus.mem_Done = 1'b1;
    tick();
    bus.mem_Done = 1'b0;
    check("idle_done_perf", perf_err, 1'b1);
    check("idle_done_reqs", stat_reqs, 16'd0);

    pulse_clr();
    bus.mem_DataOut = 16'hBEEF;
    run_req("tmo", 1'b0, 16'h0070, 16'h0000, 0, 1'b0, 16'hBEEF);
    check("tmo_flag", timeout_err, 1'b1);
    check("tmo_reqs", stat_reqs, 16'd1);
    check("tmo_hits", stat_hits, 16'd0);

    bus.mem_Stall = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 16'h0020;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.req_ready || bus.mem_Rd || bus.mem_Wr) bad++;
      tick();
    end
    check("stall_blocked", bad, 0);
    bus.mem_Stall = 1'b0;
    #1;
    check("stall_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    check("stall_accept", bus.mem_Rd, 1'b1);
    check("stall_addr", bus.mem_Addr, 16'h0020);
    bus.mem_Done     = 1'b1;
    bus.mem_CacheHit = 1'b1;
    bus.mem_DataOut  = 16'h5555;
    tick();
    bus.mem_Done     = 1'b0;
    bus.mem_CacheHit = 1'b0;
    check("b2b_rvalid", bus.resp_valid, 1'b1);
    check("b2b_rdata", bus.resp_rdata, 16'h5555);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0030;
    #1;
    check("b2b_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    check("b2b_accept", bus.mem_Rd, 1'b1);
    check("b2b_addr", bus.mem_Addr, 16'h0030);
    repeat (3) tick();

    rst = 1'b0;
    #1;
    check("midrst_rd", bus.mem_Rd, 1'b0);
    check("midrst_addr", bus.mem_Addr, 16'h0000);
    check("midrst_rvalid", bus.resp_valid, 1'b0);
    check("midrst_reqs", stat_reqs, 16'd0);
    tick();
    rst = 1'b1;
    tick();
    check("postrst_rvalid", bus.resp_valid, 1'b0);
    check("postrst_rd", bus.mem_Rd, 1'b0);

    run_req("pre_clr", 1'b1, 16'h0080, 16'h0001, 1, 1'b1, 16'h0000);
    check("pre_clr_reqs", stat_reqs, 16'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 16'h0081;
    bus.req_wdata = 16'h0002;
    tick();
    bus.req_valid    = 1'b0;
    bus.mem_Done     = 1'b1;
    bus.mem_CacheHit = 1'b1;
    clr_stats        = 1'b1;
    tick();
    bus.mem_Done     = 1'b0;
    bus.mem_CacheHit = 1'b0;
    clr_stats        = 1'b0;
    check("clr_done_rvalid", bus.resp_valid, 1'b1);
    check("clr_done_reqs", stat_reqs, 16'd0);
    check("clr_done_hits", stat_hits, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
